// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: sequences LLR load, CN/VN iterations and syndrome check for one LDPC frame
module ldpc_iter_ctrl #(
  parameter int ITER_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITER_BITS-1:0] max_iter,
  input  logic                 ld_done,
  input  logic                 cn_done,
  input  logic                 vn_done,
  input  logic                 syn_ok,
  input  logic [ITER_BITS-1:0] cnt_count,
  input  logic                 cnt_stop,
  output logic                 ld_start,
  output logic                 cn_start,
  output logic                 vn_start,
  output logic                 cnt_en,
  output logic                 cnt_rst,
  output logic [ITER_BITS-1:0] cnt_stop_val,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic [ITER_BITS-1:0] iters_used
);
  typedef enum logic [2:0] {IDLE, LOAD, CN, VN, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic ld_start_q, ld_start_d, cn_start_q, cn_start_d, vn_start_q, vn_start_d;
  logic cnt_en_q, cnt_en_d, cnt_rst_q, cnt_rst_d, busy_q, busy_d;
  logic done_q, done_d, success_q, success_d;
  logic [ITER_BITS-1:0] stop_val_q, stop_val_d, iters_q, iters_d;
  always_comb begin
    state_d    = state_q;
    ld_start_d = 1'b0;
    cn_start_d = 1'b0;
    vn_start_d = 1'b0;
    cnt_en_d   = 1'b0;
    cnt_rst_d  = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    success_d  = success_q;
    iters_d    = iters_q;
    stop_val_d = stop_val_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = LOAD;
        ld_start_d = 1'b1;
        cnt_rst_d  = 1'b1;
        busy_d     = 1'b1;
        success_d  = 1'b0;
        iters_d    = '0;
        stop_val_d = (max_iter == '0) ? '0 : max_iter - 1'b1;
      end
      LOAD: if (ld_done) begin
        state_d    = CN;
        cn_start_d = 1'b1;
      end
      CN: if (cn_done) begin
        state_d    = VN;
        vn_start_d = 1'b1;
      end
      VN: if (vn_done) state_d = CHECK;
      CHECK: if (syn_ok || cnt_stop) begin
        state_d   = DONE;
        success_d = syn_ok;
        iters_d   = cnt_count + 1'b1;
      end else begin
        state_d    = CN;
        cnt_en_d   = 1'b1;
        cn_start_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_start_q <= 1'b0;
      cn_start_q <= 1'b0;
      vn_start_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      iters_q    <= '0;
      stop_val_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_start_q <= ld_start_d;
      cn_start_q <= cn_start_d;
      vn_start_q <= vn_start_d;
      cnt_en_q   <= cnt_en_d;
      cnt_rst_q  <= cnt_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      success_q  <= success_d;
      iters_q    <= iters_d;
      stop_val_q <= stop_val_d;
    end
  end
  assign ld_start     = ld_start_q;
  assign cn_start     = cn_start_q;
  assign vn_start     = vn_start_q;
  assign cnt_en       = cnt_en_q;
  assign cnt_rst      = cnt_rst_q;
  assign cnt_stop_val = stop_val_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign success      = success_q;
  assign iters_used   = iters_q;
endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: randomized frames against an iteration-count model, with counter and phase responders
module tb_ldpc_iter_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] max_iter = '0;
  logic ld_done = 1'b0, cn_done = 1'b0, vn_done = 1'b0;
  logic syn_ok, cnt_stop;
  logic [2:0] cnt_count = '0;
  logic ld_start, cn_start, vn_start, cnt_en, cnt_rst, busy, done, success;
  logic [2:0] cnt_stop_val, iters_used;
  int errors = 0, checks = 0;
  int ok_at = 0, vn_seen = 0;
  bit vn_resp_en = 1'b1;
  int n_ld = 0, n_cn = 0, n_vn = 0, n_en = 0, n_rs = 0, n_dn = 0;

  ldpc_iter_ctrl #(.ITER_BITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .ld_done(ld_done), .cn_done(cn_done), .vn_done(vn_done), .syn_ok(syn_ok),
    .cnt_count(cnt_count), .cnt_stop(cnt_stop),
    .ld_start(ld_start), .cn_start(cn_start), .vn_start(vn_start),
    .cnt_en(cnt_en), .cnt_rst(cnt_rst), .cnt_stop_val(cnt_stop_val),
    .busy(busy), .done(done), .success(success), .iters_used(iters_used)
  );

  always #5 clk = ~clk;

  // iteration counter and 1-cycle phase responders; syn_ok fires on the ok_at-th CHECK
  always @(posedge clk) begin
    cnt_count <= (rst || cnt_rst) ? 3'd0 : cnt_en ? cnt_count + 3'd1 : cnt_count;
    ld_done   <= ld_start;
    cn_done   <= cn_start;
    vn_done   <= vn_start && vn_resp_en;
    vn_seen   <= (rst || ld_start) ? 0 : vn_done ? vn_seen + 1 : vn_seen;
  end
  assign cnt_stop = (cnt_count == cnt_stop_val);
  assign syn_ok   = (ok_at != 0) && (vn_seen == ok_at);

  always @(negedge clk) begin
    n_ld <= n_ld + int'(ld_start);
    n_cn <= n_cn + int'(cn_start);
    n_vn <= n_vn + int'(vn_start);
    n_en <= n_en + int'(cnt_en);
    n_rs <= n_rs + int'(cnt_rst);
    n_dn <= n_dn + int'(done);
  end

  task automatic run_frame(input logic [2:0] m, input int k, input bit hold_start, input string nm);
    int eff, exp_it, cyc, b_ld, b_cn, b_vn, b_en, b_rs, b_dn;
    bit exp_ok;
    eff    = (m == 0) ? 1 : int'(m);
    exp_ok = (k >= 1) && (k <= eff);
    exp_it = exp_ok ? k : eff;
    @(negedge clk);
    ok_at = k; max_iter = m;
    b_ld = n_ld; b_cn = n_cn; b_vn = n_vn; b_en = n_en; b_rs = n_rs; b_dn = n_dn;
    start = 1'b1;
    @(negedge clk);
    start = hold_start;
    max_iter = 3'($urandom);
    checks++;
    if (busy !== 1'b1 || cnt_stop_val !== 3'(eff - 1)) begin
      errors++;
      $display("FAIL %s load: busy=%b stop_val=%0d, want busy=1 stop_val=%0d", nm, busy, cnt_stop_val, eff - 1);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within 200 cycles", nm);
      return;
    end
    checks++;
    if (success !== exp_ok || iters_used !== 3'(exp_it) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: success=%b iters=%0d busy=%b, want success=%b iters=%0d busy=0",
               nm, success, iters_used, busy, exp_ok, exp_it);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_cn - b_cn != exp_it || n_vn - b_vn != exp_it || n_en - b_en != exp_it - 1) begin
      errors++;
      $display("FAIL %s phases: cn=%0d vn=%0d en=%0d, want cn=%0d vn=%0d en=%0d",
               nm, n_cn - b_cn, n_vn - b_vn, n_en - b_en, exp_it, exp_it, exp_it - 1);
    end
    checks++;
    if (n_ld - b_ld != 1 || n_rs - b_rs != 1 || n_dn - b_dn != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s framing: ld=%0d rst=%0d done=%0d busy=%b, want 1 1 1 0",
               nm, n_ld - b_ld, n_rs - b_rs, n_dn - b_dn, busy);
    end
    checks++;
    if (success !== exp_ok || iters_used !== 3'(exp_it)) begin
      errors++;
      $display("FAIL %s hold: success=%b iters=%0d, want %b %0d", nm, success, iters_used, exp_ok, exp_it);
    end
  endtask

  task automatic check_quiet(input string nm);
    checks++;
    if ({ld_start, cn_start, vn_start, cnt_en, cnt_rst, busy, done, success} !== 8'd0 ||
        cnt_stop_val !== 3'd0 || iters_used !== 3'd0) begin
      errors++;
      $display("FAIL %s: pulses/busy/done/success=%b stop_val=%0d iters=%0d, want all 0", nm,
               {ld_start, cn_start, vn_start, cnt_en, cnt_rst, busy, done, success}, cnt_stop_val, iters_used);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");
  endtask

  task automatic test_directed;
    run_frame(3'd5, 0, 1'b0, "max5_nosyn");
    run_frame(3'd5, 2, 1'b0, "max5_syn2");
    run_frame(3'd1, 0, 1'b0, "max1");
    run_frame(3'd0, 0, 1'b0, "max0");
    run_frame(3'd3, 3, 1'b0, "syn_and_stop");
    run_frame(3'd7, 0, 1'b0, "max7");
  endtask

  task automatic test_start_ignored;
    run_frame(3'd4, 0, 1'b1, "start_held");
    run_frame(3'd2, 1, 1'b0, "after_held");
  endtask

  task automatic test_rst_mid;
    int cyc = 0;
    vn_resp_en = 1'b0;
    @(negedge clk);
    ok_at = 0; max_iter = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (vn_start !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (vn_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: vn_start never seen");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid");
    rst = 1'b0;
    vn_resp_en = 1'b1;
    run_frame(3'd4, 0, 1'b0, "after_rst");
    run_frame(3'd4, 1, 1'b0, "after_rst_syn1");
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++)
      run_frame(3'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_ignored;
    test_rst_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
